axi_write_arbiter: RTL and testbench

//  2->1 AXI3 write-path arbiter between two CPU-side write masters (ch0 = dcache/uncached store,
//  ch1 = write-back buffer) and one 32-bit AXI master port. Holds one write transaction at a

---
 rtl/axi_write_arbiter_if.sv | 58 +++++
 rtl/axi_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_write_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_if.sv
// Bundled AXI3 write-path signals for the 2->1 write arbiter: two CPU-side channels and one master port.
// No logic and no added latency; each handshake follows ordinary AXI valid/ready rules.
// The slave modport is the arbiter's view and the master modport is the driver's view.
interface axi_write_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [2*ID_W-1:0]     s_axi_awid;
    logic [2*ADDR_W-1:0]   s_axi_awaddr;
    logic [2*LEN_W-1:0]    s_axi_awlen;
    logic [5:0]            s_axi_awsize;
    logic [1:0]            s_axi_awvalid;
    logic [1:0]            s_axi_awready;
    logic [2*DATA_W-1:0]   s_axi_wdata;
    logic [2*DATA_W/8-1:0] s_axi_wstrb;
    logic [1:0]            s_axi_wlast;
    logic [1:0]            s_axi_wvalid;
    logic [1:0]            s_axi_wready;
    logic [1:0]            s_axi_bvalid;
    logic [1:0]            s_axi_bready;

    logic [ID_W-1:0]       m_axi_awid;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic [LEN_W-1:0]      m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ID_W-1:0]       m_axi_wid;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bvalid,
        output s_axi_awready, s_axi_wready, s_axi_bvalid,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
        output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awvalid,
        input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// 2->1 AXI3 write arbiter: one transaction at a time (AW, W burst, B) with kseg0/kseg1 address remap.
// Minimum single-beat write takes 4 cycles from IDLE back to IDLE; AW is registered, W and B pass through.
// W and B ready/valid are forwarded only for the granted channel. WR_ARB_RR_EN selects round-robin; otherwise ch0 has fixed priority.
module axi_write_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_write_arbiter_if.slave  bus,
    output logic                wlast_err
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]    awlen_q, awlen_d;
    logic [ID_W-1:0]     awid_q, awid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [2:0]          awsize_q, awsize_d;
    logic                wlast_err_q, wlast_err_d;
    logic                arb_sel;
    logic                wlast_gen;
    logic [1:0]          aw_rdy, w_rdy, b_vld;

    // kseg0 (100) and kseg1 (101) both fold onto physical address zero-based
    function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = a;
        if (a[31:30] == 2'b10) r[31:29] = 3'b000;
        return r;
    endfunction

`ifdef WR_ARB_RR_EN
    always_comb begin
        if (&bus.s_axi_awvalid) arb_sel = ~last_grant_q;
        else                    arb_sel = ~bus.s_axi_awvalid[0];
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
    assign arb_sel = ~bus.s_axi_awvalid[0];
`endif

    assign wlast_gen = (beat_cnt_q == awlen_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        awlen_d      = awlen_q;
        awid_d       = awid_q;
        awaddr_d     = awaddr_q;
        awsize_d     = awsize_q;
        wlast_err_d  = wlast_err_q;
        aw_rdy       = 2'b00;
        w_rdy        = 2'b00;
        b_vld        = 2'b00;

        bus.m_axi_awid    = awid_q;
        bus.m_axi_awaddr  = awaddr_q;
        bus.m_axi_awlen   = awlen_q;
        bus.m_axi_awsize  = awsize_q;
        bus.m_axi_awvalid = 1'b0;
        bus.m_axi_wid     = awid_q;
        bus.m_axi_wdata   = grant_q ? bus.s_axi_wdata[2*DATA_W-1:DATA_W] : bus.s_axi_wdata[DATA_W-1:0];
        bus.m_axi_wstrb   = grant_q ? bus.s_axi_wstrb[2*STRB_W-1:STRB_W] : bus.s_axi_wstrb[STRB_W-1:0];
        bus.m_axi_wlast   = 1'b0;
        bus.m_axi_wvalid  = 1'b0;
        bus.m_axi_bready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aresetn && (|bus.s_axi_awvalid)) begin
                    aw_rdy[arb_sel] = 1'b1;
                    grant_d    = arb_sel;
                    awid_d     = arb_sel ? bus.s_axi_awid[2*ID_W-1:ID_W] : bus.s_axi_awid[ID_W-1:0];
                    awaddr_d   = remap(arb_sel ? bus.s_axi_awaddr[2*ADDR_W-1:ADDR_W]
                                               : bus.s_axi_awaddr[ADDR_W-1:0]);
                    awlen_d    = arb_sel ? bus.s_axi_awlen[2*LEN_W-1:LEN_W] : bus.s_axi_awlen[LEN_W-1:0];
                    awsize_d   = arb_sel ? bus.s_axi_awsize[5:3] : bus.s_axi_awsize[2:0];
                    beat_cnt_d = '0;
                    state_d    = ST_AW;
                end
            end
            ST_AW: begin
                bus.m_axi_awvalid = 1'b1;
                if (bus.m_axi_awready) state_d = ST_W;
            end
            ST_W: begin
                bus.m_axi_wvalid = bus.s_axi_wvalid[grant_q];
                bus.m_axi_wlast  = wlast_gen;
                w_rdy[grant_q]   = bus.m_axi_wready;
                if (bus.s_axi_wvalid[grant_q] && bus.m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (bus.s_axi_wlast[grant_q] != wlast_gen) wlast_err_d = 1'b1;
                    if (wlast_gen) state_d = ST_B;
                end
            end
            ST_B: begin
                b_vld[grant_q]   = bus.m_axi_bvalid;
                bus.m_axi_bready = bus.s_axi_bready[grant_q];
                if (bus.m_axi_bvalid && bus.s_axi_bready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.s_axi_awready = aw_rdy;
    assign bus.s_axi_wready  = w_rdy;
    assign bus.s_axi_bvalid  = b_vld;
    assign wlast_err         = wlast_err_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            awlen_q      <= '0;
            awid_q       <= '0;
            awaddr_q     <= '0;
            awsize_q     <= '0;
            wlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            awlen_q      <= awlen_d;
            awid_q       <= awid_d;
            awaddr_q     <= awaddr_d;
            awsize_q     <= awsize_d;
            wlast_err_q  <= wlast_err_d;
        end
    end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: remap, bursts, arbitration order, WLAST error and reset.
module tb_axi_write_arbiter;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic wlast_err;
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;

    axi_write_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    axi_write_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .wlast_err (wlast_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
        edges++;
    endtask

    function automatic logic [31:0] pat(input int ch, input int beat);
        return 32'hD000_0000 | (32'(ch) << 8) | 32'(beat);
    endfunction

    task automatic idle_inputs();
        bus.s_axi_awid    = '0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awlen   = '0;
        bus.s_axi_awsize  = '0;
        bus.s_axi_awvalid = '0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wlast   = '0;
        bus.s_axi_wvalid  = '0;
        bus.s_axi_bready  = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
    endtask

    // Called 2ns after a posedge with the DUT in IDLE; ch is the expected winner.
    task automatic do_write(input int ch, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] exp_addr, input bit zw, input bit toggle,
                            input int bad_beat);
        int         oth;
        int         beat;
        int         cyc;
        logic       wr;
        logic [1:0] onehot;
        logic [3:0] id;
        oth    = 1 - ch;
        beat   = 0;
        cyc    = 0;
        onehot = 2'b01 << ch;
        id     = (ch == 0) ? 4'h3 : 4'hC;
        bus.s_axi_awid[ch*ID_W +: ID_W]       = id;
        bus.s_axi_awaddr[ch*ADDR_W +: ADDR_W] = addr;
        bus.s_axi_awlen[ch*LEN_W +: LEN_W]    = len;
        bus.s_axi_awsize[ch*3 +: 3]           = 3'd2;
        bus.s_axi_awvalid[ch]                 = 1'b1;
        #1;
        chk("awready_idle", bus.s_axi_awready, onehot);
        chk("m_awvalid_idle", bus.m_axi_awvalid, 0);
        tick();
        bus.s_axi_awvalid[ch] = 1'b0;
        bus.m_axi_awready     = zw;
        bus.s_axi_wvalid      = 2'b11;
        bus.s_axi_wdata       = {2{32'hBAD0_0000}};
        #1;
        chk("m_awvalid", bus.m_axi_awvalid, 1);
        chk("m_awaddr", bus.m_axi_awaddr, exp_addr);
        chk("m_awid", bus.m_axi_awid, id);
        chk("m_awlen", bus.m_axi_awlen, len);
        chk("m_awsize", bus.m_axi_awsize, 3'd2);
        chk("awready_busy", bus.s_axi_awready, 0);
        chk("s_wready_early", bus.s_axi_wready, 0);
        chk("m_wvalid_early", bus.m_axi_wvalid, 0);
        if (!zw) begin
            tick();
            bus.m_axi_awready = 1'b1;
            #1;
            chk("m_awvalid_hold", bus.m_axi_awvalid, 1);
            chk("m_awaddr_hold", bus.m_axi_awaddr, exp_addr);
        end
        tick();
        while (beat <= 32'(len) && cyc < 40) begin
            wr = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.m_axi_wready                      = wr;
            bus.s_axi_wvalid                      = 2'b11;
            bus.s_axi_wdata[ch*DATA_W +: DATA_W]  = pat(ch, beat);
            bus.s_axi_wdata[oth*DATA_W +: DATA_W] = 32'hBAD0_0000;
            bus.s_axi_wstrb                       = 8'h00;
            bus.s_axi_wstrb[ch*4 +: 4]            = 4'hF;
            bus.s_axi_wlast[oth]                  = 1'b1;
            bus.s_axi_wlast[ch]                   = (beat == bad_beat) || (beat == 32'(len));
            #1;
            chk("m_wvalid", bus.m_axi_wvalid, 1);
            chk("m_wdata", bus.m_axi_wdata, pat(ch, beat));
            chk("m_wstrb", bus.m_axi_wstrb, 4'hF);
            chk("m_wlast", bus.m_axi_wlast, beat == 32'(len));
            chk("m_wid", bus.m_axi_wid, id);
            chk("s_wready", bus.s_axi_wready, wr ? onehot : 2'b00);
            tick();
            if (wr) beat++;
            cyc++;
        end
        chk("w_beats", beat, 32'(len) + 1);
        bus.s_axi_wvalid = 2'b00;
        bus.s_axi_wlast  = 2'b00;
        bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b1;
        bus.s_axi_bready = zw ? onehot : (2'b11 ^ onehot);
        #1;
        chk("s_bvalid", bus.s_axi_bvalid, onehot);
        chk("m_bready", bus.m_axi_bready, zw);
        if (!zw) begin
            tick();
            bus.s_axi_bready = onehot;
            #1;
            chk("s_bvalid_hold", bus.s_axi_bvalid, onehot);
            chk("m_bready_late", bus.m_axi_bready, 1);
        end
        tick();
        bus.m_axi_bvalid  = 1'b0;
        bus.s_axi_bready  = 2'b00;
        bus.m_axi_awready = 1'b0;
        #1;
        chk("s_bvalid_done", bus.s_axi_bvalid, 0);
        chk("m_awvalid_done", bus.m_axi_awvalid, 0);
    endtask

    initial begin
        idle_inputs();
        bus.s_axi_awvalid = 2'b01;
        tick();
        tick();
        #1;
        chk("rst_awready", bus.s_axi_awready, 0);
        chk("rst_m_awvalid", bus.m_axi_awvalid, 0);
        chk("rst_m_wvalid", bus.m_axi_wvalid, 0);
        chk("rst_s_wready", bus.s_axi_wready, 0);
        chk("rst_s_bvalid", bus.s_axi_bvalid, 0);
        chk("rst_m_bready", bus.m_axi_bready, 0);
        chk("rst_wlast_err", wlast_err, 0);
        bus.s_axi_awvalid = 2'b00;
        aresetn = 1'b1;
        tick();

        edges = 0;
        do_write(0, 32'hA000_1000, 4'd0, 32'h0000_1000, 1'b1, 1'b0, -1);
        chk("single_cycles", edges, 4);

        do_write(1, 32'h1FC0_0000, 4'd3, 32'h1FC0_0000, 1'b0, 1'b1, -1);
        do_write(0, 32'hBFC0_0004, 4'd0, 32'h1FC0_0004, 1'b1, 1'b0, -1);
        do_write(1, 32'hC000_0010, 4'd1, 32'hC000_0010, 1'b1, 1'b0, -1);
        do_write(0, 32'h8000_0000, 4'd15, 32'h0000_0000, 1'b1, 1'b0, -1);

        chk("wlast_err_clean", wlast_err, 0);
        do_write(0, 32'h0000_2000, 4'd1, 32'h0000_2000, 1'b1, 1'b0, 0);
        chk("wlast_err_set", wlast_err, 1);
        do_write(1, 32'h0000_3000, 4'd0, 32'h0000_3000, 1'b1, 1'b0, -1);
        chk("wlast_err_sticky", wlast_err, 1);

        bus.s_axi_awaddr[31:0] = 32'h0000_4000;
        bus.s_axi_awlen[3:0]   = 4'd3;
        bus.s_axi_awvalid      = 2'b01;
        tick();
        bus.s_axi_awvalid = 2'b00;
        bus.m_axi_awready = 1'b1;
        tick();
        bus.m_axi_awready = 1'b0;
        bus.s_axi_wvalid  = 2'b01;
        bus.m_axi_wready  = 1'b0;
        #1;
        chk("pre_rst_m_wvalid", bus.m_axi_wvalid, 1);
        aresetn = 1'b0;
        tick();
        #1;
        chk("midrst_m_awvalid", bus.m_axi_awvalid, 0);
        chk("midrst_m_wvalid", bus.m_axi_wvalid, 0);
        chk("midrst_s_wready", bus.s_axi_wready, 0);
        chk("midrst_s_bvalid", bus.s_axi_bvalid, 0);
        chk("midrst_m_bready", bus.m_axi_bready, 0);
        chk("midrst_wlast_err", wlast_err, 0);
        aresetn          = 1'b1;
        bus.s_axi_wvalid = 2'b00;
        tick();
        #1;
        chk("postrst_m_awvalid", bus.m_axi_awvalid, 0);
        chk("postrst_s_awready", bus.s_axi_awready, 0);

        bus.s_axi_awid[7:4]    = 4'hC;
        bus.s_axi_awaddr[63:32] = 32'h0000_5000;
        bus.s_axi_awvalid[1]   = 1'b1;
`ifdef WR_ARB_RR_EN
        do_write(0, 32'h0000_6000, 4'd0, 32'h0000_6000, 1'b1, 1'b0, -1);
        bus.s_axi_awvalid[0] = 1'b1;
        do_write(1, 32'h0000_5000, 4'd0, 32'h0000_5000, 1'b1, 1'b0, -1);
        do_write(0, 32'h0000_6000, 4'd0, 32'h0000_6000, 1'b1, 1'b0, -1);
`else
        do_write(0, 32'h0000_6000, 4'd0, 32'h0000_6000, 1'b1, 1'b0, -1);
        do_write(0, 32'h0000_7000, 4'd1, 32'h0000_7000, 1'b1, 1'b0, -1);
        do_write(1, 32'h0000_5000, 4'd0, 32'h0000_5000, 1'b1, 1'b0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
